// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared state encodings and constants for the instruction fetch unit
package ifu_fetch_pkg;

    // Default widths used when the top is instantiated without overrides
    localparam int IFU_XLEN     = 64;
    localparam int IFU_INST_LEN = 32;

    // PC loaded on reset
    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    // addi x0, x0, 0 - presented to decode whenever no real instruction is held
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_HOLD = 3'd3,
        IFU_DROP = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC owner, single-outstanding imem requester, decode feeder (optional IFU_MISALIGN_CHK_EN)
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int               XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IFU_RESET_PC),
    parameter int               INST_LEN = IFU_INST_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [INST_LEN-1:0] imem_resp_data,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INST_LEN-1:0] instr_o,
    output logic [XLEN-1:0]     pc_o,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                fetch_misalign
`endif
);

    localparam logic [INST_LEN-1:0] NOP = INST_LEN'(NOP_INST);

    ifu_state_e         state;
    ifu_state_e         nxt_state;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    nxt_pc;
    logic               capture;

    // The request address is always the architectural fetch PC
    assign imem_req_addr = pc;

    // Next-state and next-PC decode; a redirect always overrides sequential PC advance
    always_comb begin
        nxt_state = state;
        nxt_pc    = pc;
        capture   = 1'b0;
        case (state)
            IFU_IDLE: begin
                nxt_state = IFU_REQ;
            end
            IFU_REQ: begin
                if (redirect_valid) begin
                    nxt_pc    = redirect_pc;
                    // an accepted request in the redirect cycle fetches the old PC, so it is stale
                    nxt_state = imem_req_ready ? IFU_DROP : IFU_REQ;
                end else if (imem_req_ready) begin
                    nxt_state = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    nxt_pc    = redirect_pc;
                    nxt_state = imem_resp_valid ? IFU_REQ : IFU_DROP;
                end else if (imem_resp_valid) begin
                    capture   = 1'b1;
                    nxt_state = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                if (redirect_valid) begin
                    nxt_pc    = redirect_pc;
                    nxt_state = IFU_REQ;
                end else if (instr_ready) begin
                    nxt_pc    = pc + XLEN'(4);
                    nxt_state = IFU_REQ;
                end
            end
            IFU_DROP: begin
                if (redirect_valid) begin
                    nxt_pc = redirect_pc;
                end
                if (imem_resp_valid) begin
                    nxt_state = IFU_REQ;
                end
            end
            default: begin
                nxt_state = IFU_IDLE;
            end
        endcase
    end

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_enter;

    // Entering REQ with a misaligned PC traps straight to HOLD without touching memory
    assign misalign_enter = (nxt_state == IFU_REQ) && (nxt_pc[1:0] != 2'b00);
`endif

    // State, PC and registered outputs; every output is a flop so decode and imem see clean timing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IFU_IDLE;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr_o        <= NOP;
            pc_o           <= RESET_PC;
`ifdef IFU_MISALIGN_CHK_EN
            fetch_misalign <= 1'b0;
`endif
        end else begin
            pc <= nxt_pc;
            if (capture) begin
                instr_o <= imem_resp_data;
                pc_o    <= pc;
            end
`ifdef IFU_MISALIGN_CHK_EN
            if (misalign_enter) begin
                state          <= IFU_HOLD;
                imem_req_valid <= 1'b0;
                instr_valid    <= 1'b1;
                fetch_misalign <= 1'b1;
                instr_o        <= NOP;
                pc_o           <= nxt_pc;
            end else begin
                state          <= nxt_state;
                imem_req_valid <= (nxt_state == IFU_REQ);
                instr_valid    <= (nxt_state == IFU_HOLD);
                if ((state == IFU_HOLD) && (nxt_state != IFU_HOLD)) begin
                    fetch_misalign <= 1'b0;
                end
            end
`else
            state          <= nxt_state;
            imem_req_valid <= (nxt_state == IFU_REQ);
            instr_valid    <= (nxt_state == IFU_HOLD);
`endif
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; the producing end of the decoder's instruction input.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents {instr_o, pc_o} to the decode stage with a valid/ready handshake.
- Accepts PC redirects from branch control and discards stale fetches after a redirect.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h8000_0000, PC value loaded on reset.
- INST_LEN, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address; equals the PC.
- imem_resp_valid  in  1  response data valid, one cycle pulse.
- imem_resp_data  in  INST_LEN  fetched instruction word.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode consumes the instruction.
- instr_o  out  INST_LEN  instruction to decode.
- pc_o  out  XLEN  PC of instr_o.
- redirect_valid  in  1  branch/jump taken, one cycle pulse.
- redirect_pc  in  XLEN  redirect target.

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - imem_req_valid=0, instr_valid=0.
  - instr_o=32'h0000_0013 (nop), pc_o=RESET_PC.
  - Reset mid-operation abandons any outstanding request. Memory must not deliver a response for a request issued before reset.
- States:
  - IDLE: unconditional transition to REQ next cycle.
  - REQ: imem_req_valid=1, imem_req_addr=pc.
    - req_ready && !redirect: go to WAIT.
    - redirect && !req_ready: pc=redirect_pc, stay in REQ.
    - redirect && req_ready: pc=redirect_pc, go to DROP; the accepted request is stale.
    - Address stays stable while valid and !ready, except on redirect.
  - WAIT: imem_req_valid=0, waiting for the response.
    - resp_valid && !redirect: instr_o=resp_data, pc_o=pc, go to HOLD.
    - redirect && !resp_valid: pc=redirect_pc, go to DROP.
    - redirect && resp_valid: discard data, pc=redirect_pc, go to REQ.
  - HOLD: instr_valid=1; instr_o and pc_o stay stable until the handshake.
    - redirect: pc=redirect_pc, go to REQ, instr_valid=0 next cycle. Redirect wins over a simultaneous instr_ready.
    - instr_ready && !redirect: pc=pc+4 (wraps modulo 2^XLEN), go to REQ.
  - DROP: wait for the stale response.
    - resp_valid: discard it, go to REQ.
    - A redirect in DROP updates pc only; the state stays DROP.
- Outstanding request limit: one. No new request is issued before the previous response arrives.
- Latency:
  - Zero-wait memory (ready=1, response the cycle after accept) gives REQ→WAIT→HOLD.
  - instr_valid rises 2 cycles after REQ entry.
  - Throughput is 1 instruction per 3 cycles with instr_ready tied high.
- instr_valid never asserts for a response that was fetched before a redirect.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit), reset 0.
  - On entering REQ with pc[1:0]!=0, no memory request is issued; state goes to HOLD with instr_valid=1, fetch_misalign=1, instr_o=nop, pc_o=pc.
  - fetch_misalign clears with the HOLD handshake or a redirect.
- Undefined: no port; pc[1:0] is ignored and the request is issued as-is.

Decomposition:
- Shared defines file:
  - State encodings IFU_IDLE/REQ/WAIT/HOLD/DROP (3 bits).
  - NOP_INST constant 32'h0000_0013.
  - RESET_PC default.
  - Existing XLEN/inst_len macros.
- No sub-module; the single FSM plus PC register is natural.
- Optionally split out ifu_pc_reg if a branch predictor is added later.

Test Plan:
- Reset release, zero-wait memory, instr_ready=1 → req addrs 0x8000_0000, 0x8000_0004, 0x8000_0008; instr_valid once per 3 cycles with matching pc_o.
- Hold instr_ready=0 for 5 cycles in HOLD → instr_o/pc_o stable, no new imem_req_valid; PC advances by 4 only after ready.
- Redirect to 0x8000_0100 while in WAIT (resp 2 cycles later) → stale response discarded, instr_valid stays 0, next req addr 0x8000_0100.
- Redirect and instr_ready in the same HOLD cycle → next request at the redirect target, not pc+4.
- imem_req_ready low 4 cycles then redirect → request addr switches to the target while valid, then is accepted; the fetched word carries the target pc_o.
- With IFU_MISALIGN_CHK_EN, redirect to 0x8000_0102 → no imem request, instr_valid=1, fetch_misalign=1, instr_o=0x0000_0013.
